// File: rtl/oam_sprite_evaluator.sv
// oam_sprite_evaluator: per-scanline OAM scan. Walks every OAM entry in
// address order and writes up to MAX_SPRITES entries whose vertical extent
// covers the requested scanline into the sprite line buffer.
// Optional feature macro: SPRITE_OVERFLOW_EN. When it is defined, scanning
// continues after the buffer fills and a sticky overflow flag is raised.
// When it is undefined, the scan stops as soon as the buffer is full.
module oam_sprite_evaluator #(
    parameter  int NUM_ENTRIES = 64,
    parameter  int MAX_SPRITES = 8,
    localparam int AW          = $clog2(NUM_ENTRIES),
    localparam int SW          = $clog2(MAX_SPRITES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [7:0]    scanline_i,
    input  logic          tall_sprites_i,
    output logic [AW-1:0] oam_read_addr_o,
    input  logic [31:0]   oam_read_data_i,
    output logic          sel_we_o,
    output logic [SW-1:0] sel_addr_o,
    output logic [35:0]   sel_data_o,
    output logic [SW:0]   sel_count_o,
    output logic          overflow_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ENTRIES - 1);
    localparam logic [SW:0]   FULL_CNT  = (SW+1)'(MAX_SPRITES);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    line_q, line_d;
    logic          tall_q, tall_d;
    logic          vld_q, vld_d;     // read data on the bus belongs to this scan
    logic          we_q, we_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [35:0]   data_q, data_d;
    logic [SW:0]   cnt_q, cnt_d;
`ifdef SPRITE_OVERFLOW_EN
    logic          ovf_q, ovf_d;
`endif

    logic [8:0] diff;
    logic       in_range;
    logic       full;
    logic       hit;
    logic       wr;

    // Range compare on the entry returned for the previous address.
    always_comb begin
        diff     = {1'b0, line_q} - {1'b0, oam_read_data_i[7:0]};
        // The borrow bit rules out Y > scanline, so there is no wrap-around.
        in_range = !diff[8] && (diff[7:0] < (tall_q ? 8'd16 : 8'd8));
        full     = (cnt_q == FULL_CNT);
        hit      = vld_q && (state_q == SCAN || state_q == DRAIN) && in_range;
        wr       = hit && !full;
    end

    // Next-state logic and datapath next values.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        line_d  = line_q;
        tall_d  = tall_q;
        vld_d   = (state_q == SCAN);
        we_d    = 1'b0;
        slot_d  = slot_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef SPRITE_OVERFLOW_EN
        ovf_d   = ovf_q;
        if (hit && full) begin
            ovf_d = 1'b1;
        end
`endif
        // Slot is taken from the count before it increments, so the lowest
        // OAM index always gets the lowest slot.
        if (wr) begin
            we_d   = 1'b1;
            slot_d = cnt_q[SW-1:0];
            data_d = {diff[3:0], oam_read_data_i};
            cnt_d  = cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    line_d  = scanline_i;
                    tall_d  = tall_sprites_i;
                    cnt_d   = '0;
                    addr_d  = '0;
`ifdef SPRITE_OVERFLOW_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifndef SPRITE_OVERFLOW_EN
                // The buffer is full: the read in flight is dropped (wr is
                // already blocked by full) and the scan ends.
                if (full) begin
                    state_d = DONE;
                end else
`endif
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; a reset aborts any scan in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            line_q <= '0;
            tall_q <= 1'b0;
            vld_q  <= 1'b0;
            we_q   <= 1'b0;
            slot_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
`ifdef SPRITE_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            addr_q <= addr_d;
            line_q <= line_d;
            tall_q <= tall_d;
            vld_q  <= vld_d;
            we_q   <= we_d;
            slot_q <= slot_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
`ifdef SPRITE_OVERFLOW_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign oam_read_addr_o = addr_q;
    assign sel_we_o        = we_q;
    assign sel_addr_o      = slot_q;
    assign sel_data_o      = data_q;
    assign sel_count_o     = cnt_q;
`ifdef SPRITE_OVERFLOW_EN
    assign overflow_o      = ovf_q;
`else
    assign overflow_o      = 1'b0;
`endif
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

endmodule
